// File: rtl/axis_uart_bridge_rx.sv
// axis_uart_bridge_rx
//   8N1 UART receiver. It assembles N_BYTES consecutive bytes (first byte
//   in bits [7:0]) into one word and presents that word on an AXI-Stream
//   master port. It holds at most one completed word. A word that completes
//   while the output is stalled is dropped and flagged on OVERFLOW.
//
//   Parameters: UART_SPEED (baud), FREQ_HZ (clk Hz), N_BYTES (bytes/word)
//   Ports:
//     clk, reset           system clock, synchronous active-high reset
//     UART_RX              asynchronous serial input, idles high
//     M_AXIS_TDATA/TVALID  assembled word / valid (registered)
//     M_AXIS_TREADY        consumer ready
//     OVERFLOW             1-cycle pulse when a completed word is dropped
//     FRAME_ERR            1-cycle pulse on a bad stop bit (frame check only)
//
//   Optional feature macro: AXIS_UART_BRIDGE_RX_FRAME_CHECK_EN
//     When defined, a stop bit of 0 discards the byte and the partial word,
//     and pulses FRAME_ERR. Start detection is then re-armed only after the
//     line has been seen high again. When undefined, FRAME_ERR is always 0.
`timescale 1ns/1ps
module axis_uart_bridge_rx #(
    parameter int UART_SPEED = 115200,
    parameter int FREQ_HZ    = 100000000,
    parameter int N_BYTES    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   UART_RX,
    output logic [N_BYTES*8-1:0]   M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   OVERFLOW,
    output logic                   FRAME_ERR
);

    localparam int CLOCK_DURATION = FREQ_HZ / UART_SPEED;
    localparam int HALF           = CLOCK_DURATION / 2;
    localparam int BCW            = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [31:0]    CD_LAST   = 32'(CLOCK_DURATION - 1);
    localparam logic [31:0]    HALF_LAST = 32'(HALF - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_s;
    logic [31:0]          cnt_r;
    logic [2:0]           bit_idx_r;
    logic [7:0]           shift_r;
    logic [BCW-1:0]       byte_cnt_r;
    logic [N_BYTES*8-1:0] word_r;
    logic [N_BYTES*8-1:0] word_full_s;
    logic                 armed_r;
    logic                 cnt_clr_s;
    logic                 shift_en_s;
    logic                 stop_s;
    logic                 frame_bad_s;
    logic                 byte_ok_s;
    logic                 word_done_s;

    assign rx_s = rx_sync_r;

    // Two-flop synchronizer; both stages reset to the idle line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_RX;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state and per-cycle strobes of the receive FSM.
    always_comb begin
        state_s    = state_r;
        cnt_clr_s  = 1'b0;
        shift_en_s = 1'b0;
        stop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // armed_r blocks a start after a framing error until the line is high again
                if (!rx_s && armed_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    if (!rx_s) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == CD_LAST) begin
                    shift_en_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (cnt_r == CD_LAST) begin
                    stop_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

`ifdef AXIS_UART_BRIDGE_RX_FRAME_CHECK_EN
    assign frame_bad_s = stop_s & ~rx_s;
`else
    assign frame_bad_s = 1'b0;
`endif

    assign byte_ok_s   = stop_s & ~frame_bad_s;
    assign word_done_s = byte_ok_s && (byte_cnt_r == BYTE_LAST);

    // Current partial word with the just-received byte merged into its slot.
    always_comb begin
        word_full_s = word_r;
        word_full_s[{byte_cnt_r, 3'b000} +: 8] = shift_r;
    end

    // FSM state, bit timer (cleared on every state entry) and data shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 32'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            if ((state_s != state_r) || cnt_clr_s) begin
                cnt_r <= 32'd0;
            end else begin
                cnt_r <= cnt_r + 32'd1;
            end
            if (shift_en_s) begin
                shift_r   <= {rx_s, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end else if (state_r != DATA) begin
                bit_idx_r <= 3'd0;
            end
        end
    end

    // Word assembly, byte counter and start-detection arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r     <= '0;
            byte_cnt_r <= '0;
            armed_r    <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            FRAME_ERR <= frame_bad_s;
            if (frame_bad_s) begin
                word_r     <= '0;
                byte_cnt_r <= '0;
                armed_r    <= 1'b0;
            end else if (byte_ok_s) begin
                word_r <= word_full_s;
                if (word_done_s) begin
                    byte_cnt_r <= '0;
                end else begin
                    byte_cnt_r <= byte_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
                end
            end
            if (!frame_bad_s && (state_r == IDLE) && rx_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Single-entry AXI-Stream output register with overflow detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            M_AXIS_TDATA  <= '0;
            M_AXIS_TVALID <= 1'b0;
            OVERFLOW      <= 1'b0;
        end else begin
            OVERFLOW <= 1'b0;
            if (word_done_s) begin
                if (!M_AXIS_TVALID || M_AXIS_TREADY) begin
                    M_AXIS_TDATA  <= word_full_s;
                    M_AXIS_TVALID <= 1'b1;
                end else begin
                    OVERFLOW <= 1'b1;
                end
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end
        end
    end

endmodule
